// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared PS/2 types, default timings and command/scancode bytes.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        REQ       = 3'd2,
        SHIFT     = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } ps2_tx_st_t;

    // Defaults assume a 25 MHz clock.
    localparam int unsigned c_INHIBIT_CYC_DEF = 2500;
    localparam int unsigned c_REQ_CYC_DEF     = 125;
    localparam int unsigned c_TIMEOUT_CYC_DEF = 375000;

    localparam logic [7:0] c_CMD_SET_LED = 8'hED;
    localparam logic [7:0] c_CMD_RESET   = 8'hFF;
    localparam logic [7:0] c_SC_BREAK    = 8'hF0;
    localparam logic [7:0] c_RSP_ACK     = 8'hFA;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : ps2_sync_edge
// Description : 2-flop synchronizer for a PS/2 pad plus falling-edge detect.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_pad,
    output logic o_level,
    output logic o_fell
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Reset to the idle-high line level so no edge is reported out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_pad;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_fell  = r_prev & ~r_sync;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_host_tx
// Description : Host-to-device PS/2 command transmitter with ack/timeout check.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYC = c_INHIBIT_CYC_DEF,
    parameter int unsigned REQ_CYC     = c_REQ_CYC_DEF,
    parameter int unsigned TIMEOUT_CYC = c_TIMEOUT_CYC_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       err_ack,
    output logic       err_timeout
);

    localparam int c_CNT_W = $clog2(INHIBIT_CYC + REQ_CYC + TIMEOUT_CYC + 1);
    localparam logic [c_CNT_W-1:0] c_INH_LAST = c_CNT_W'(INHIBIT_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_REQ_LAST = c_CNT_W'(REQ_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_TO_LIMIT = c_CNT_W'(TIMEOUT_CYC);

    ps2_tx_st_t         r_state;
    ps2_tx_st_t         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [8:0]         r_shift;
    logic               r_cur;
    logic [3:0]         r_bitcnt;
    logic               r_err_ack;
    logic               r_err_timeout;
    logic               w_clk_lvl;
    logic               w_clk_fe;
    logic               w_data_lvl;
    logic               w_unused_data_fe;
    logic               w_accept;
    logic               w_timeout_hit;
    logic               w_in_xfer;

    ps2_sync_edge u_clk_sync (
        .clk     (clk),
        .rst     (reset),
        .i_pad   (ps2_clk_i),
        .o_level (w_clk_lvl),
        .o_fell  (w_clk_fe)
    );

    ps2_sync_edge u_data_sync (
        .clk     (clk),
        .rst     (reset),
        .i_pad   (ps2_data_i),
        .o_level (w_data_lvl),
        .o_fell  (w_unused_data_fe)
    );

    assign w_in_xfer = (r_state == SHIFT) || (r_state == ACK);

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        tx_ready      = 1'b0;
        busy          = 1'b1;
        ps2_clk_oe    = 1'b0;
        ps2_data_oe   = 1'b0;
        done          = 1'b0;
        w_accept      = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            IDLE: begin
                tx_ready = 1'b1;
                busy     = 1'b0;
                if (tx_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = INHIBIT;
                end
            end
            INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (r_cnt == c_INH_LAST) w_state_nxt = REQ;
            end
            REQ: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = 1'b1;
                if (r_cnt == c_REQ_LAST) w_state_nxt = SHIFT;
            end
            SHIFT: begin
                ps2_data_oe = ~r_cur;
                if (w_clk_fe && (r_bitcnt == 4'd9)) w_state_nxt = ACK;
            end
            ACK: begin
                if (w_clk_fe) w_state_nxt = WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (w_clk_lvl && w_data_lvl) begin
                    done        = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // A stalled device clock ends the transfer at once, lines released.
        if (w_in_xfer && (r_cnt == c_TO_LIMIT)) begin
            w_timeout_hit = 1'b1;
            ps2_data_oe   = 1'b0;
            done          = 1'b1;
            w_state_nxt   = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt         <= '0;
            r_shift       <= '0;
            r_cur         <= 1'b0;
            r_bitcnt      <= '0;
            r_err_ack     <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            if (w_state_nxt != r_state)
                r_cnt <= '0;
            else if (w_in_xfer && w_clk_fe)
                r_cnt <= '0;
            else if (r_state != IDLE && r_state != WAIT_IDLE)
                r_cnt <= r_cnt + c_CNT_W'(1);

            if (w_accept) begin
                r_shift       <= {odd_parity(tx_data), tx_data};
                r_cur         <= 1'b0;
                r_bitcnt      <= '0;
                r_err_ack     <= 1'b0;
                r_err_timeout <= 1'b0;
            end

            // Data bits then parity are presented one per device falling edge.
            if ((r_state == SHIFT) && w_clk_fe && (r_bitcnt != 4'd9)) begin
                r_cur    <= r_shift[0];
                r_shift  <= {1'b1, r_shift[8:1]};
                r_bitcnt <= r_bitcnt + 4'd1;
            end

            if ((r_state == ACK) && w_clk_fe && !w_timeout_hit)
                r_err_ack <= w_data_lvl;

            if (w_timeout_hit) begin
                r_err_timeout <= 1'b1;
                r_err_ack     <= 1'b0;
            end
        end
    end

    assign err_ack     = r_err_ack;
    assign err_timeout = r_err_timeout | w_timeout_hit;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_host_tx
// Description : Self-checking bench with a behavioural PS/2 keyboard model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

    localparam int c_INH = 40;
    localparam int c_REQ = 10;
    localparam int c_TO  = 3000;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic       err_ack;
    logic       err_timeout;
    logic       dev_clk_low;
    logic       dev_data_low;
    logic       w_clk_line;
    logic       w_data_line;

    int total = 0;
    int bad   = 0;

    // Open-drain wired-AND of host and device drivers.
    assign w_clk_line  = !(ps2_clk_oe || dev_clk_low);
    assign w_data_line = !(ps2_data_oe || dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYC (c_INH),
        .REQ_CYC     (c_REQ),
        .TIMEOUT_CYC (c_TO)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clk_i   (w_clk_line),
        .ps2_data_i  (w_data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .done        (done),
        .err_ack     (err_ack),
        .err_timeout (err_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line frame: 8 data bits LSB first, odd parity, stop bit high.
    function automatic logic [9:0] exp_frame(input logic [7:0] b);
        logic [9:0] f;
        for (int i = 0; i < 8; i++) f[i] = (b >> i) & 8'd1;
        f[8] = ($countones(b) % 2 == 0);
        f[9] = 1'b1;
        return f;
    endfunction

    // One host send; mode: 0 normal, 1 no ack, 2 device silent, 3 reset at edge 4.
    task automatic xfer(input logic [7:0] b, input int half, input int mode, input bit inject);
        logic [9:0] smp;
        int n;
        int extra;
        smp = '0;
        repeat ($urandom_range(1, 20)) @(negedge clk);
        chk("ready_before", tx_ready, 1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        chk("clk_oe_n1", ps2_clk_oe, 1);
        chk("busy_n1", busy, 1);
        chk("ready_n1", tx_ready, 0);
        chk("err_clr", {err_ack, err_timeout}, 0);
        repeat (c_INH - 1) @(negedge clk);
        chk("data_oe_inh", ps2_data_oe, 0);
        @(negedge clk);
        chk("data_oe_req", ps2_data_oe, 1);
        repeat (c_REQ - 1) @(negedge clk);
        chk("clk_oe_req", ps2_clk_oe, 1);
        @(negedge clk);
        chk("clk_release", ps2_clk_oe, 0);
        chk("start_bit", ps2_data_oe, 1);

        if (mode == 2) begin
            n = 0;
            while (!done && n < c_TO + 20) begin
                @(negedge clk);
                n++;
            end
            chk("to_latency", n, c_TO);
            chk("to_err_timeout", err_timeout, 1);
            chk("to_err_ack", err_ack, 0);
            chk("to_oes", {ps2_clk_oe, ps2_data_oe}, 0);
            @(negedge clk);
            chk("to_ready_after", tx_ready, 1);
            chk("to_done_pulse", done, 0);
            chk("to_err_held", err_timeout, 1);
            return;
        end

        repeat (50) @(negedge clk);
        for (int e = 1; e <= 11; e++) begin
            if (e == 11 && mode == 0) dev_data_low = 1'b1;
            repeat (half) @(negedge clk);
            dev_clk_low = 1'b1;
            if (mode == 3 && e == 4) begin
                repeat (10) @(negedge clk);
                chk("k4_bit", ps2_data_oe, !b[3]);
                reset       = 1'b1;
                dev_clk_low = 1'b0;
                @(negedge clk);
                reset = 1'b0;
                chk("rst_oes", {ps2_clk_oe, ps2_data_oe}, 0);
                chk("rst_ready", tx_ready, 1);
                chk("rst_busy", busy, 0);
                return;
            end
            repeat (half) @(negedge clk);
            dev_clk_low = 1'b0;
            if (e <= 10) smp[e-1] = w_data_line;
            if (e == 11) dev_data_low = 1'b0;
            if (inject && e == 3) begin
                tx_data  = 8'h55;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
            end
        end
        chk("frame", smp, exp_frame(b));

        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done, 1);
        chk("done_err_ack", err_ack, (mode == 1) ? 1 : 0);
        chk("done_err_to", err_timeout, 0);
        chk("done_ready", tx_ready, 0);
        @(negedge clk);
        chk("ready_after", tx_ready, 1);
        chk("done_one_cycle", done, 0);
        chk("err_ack_held", err_ack, (mode == 1) ? 1 : 0);

        if (inject) begin
            extra = 0;
            repeat (500) begin
                @(negedge clk);
                if (done || busy || ps2_clk_oe) extra++;
            end
            chk("no_requeue", extra, 0);
        end
    endtask

    initial begin
        reset        = 1'b1;
        tx_data      = 8'h00;
        tx_valid     = 1'b0;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_clk_oe", ps2_clk_oe, 0);
        chk("rst_data_oe", ps2_data_oe, 0);
        chk("rst_busy0", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err_ack", err_ack, 0);
        chk("rst_err_to", err_timeout, 0);
        reset = 1'b0;

        xfer(8'hED, 750, 0, 1'b0);
        xfer(8'h07, 750, 0, 1'b0);
        xfer(8'h00, 750, 0, 1'b1);
        xfer(8'($urandom), $urandom_range(250, 400), 1, 1'b0);
        xfer(8'($urandom), 300, 2, 1'b0);
        xfer(8'($urandom), $urandom_range(250, 400), 3, 1'b0);
        xfer(8'hFF, $urandom_range(250, 400), 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte, for example LED set (0xED) or reset (0xFF), from the FPGA to the attached keyboard. It drives the open-drain PS/2 clock and data lines through output-enable pins, follows the device-generated clock, checks the device acknowledge and reports completion or error. It sits beside the existing PS/2 receiver in `ctrl_main_block`; `busy` gates that receiver while a command is in flight.

## Interface
- `INHIBIT_CYC`, default 2500, clock-inhibit hold in cycles (100 us at 25 MHz).
- `REQ_CYC`, default 125, data-low-before-clock-release hold in cycles (5 us).
- `TIMEOUT_CYC`, default 375000, maximum wait per device clock edge (15 ms).

Ports:
- `clk` in 1: 25 MHz pixel clock; single clock domain.
- `reset` in 1: synchronous, active-high.
- `tx_data` in 8: command byte.
- `tx_valid` in 1: request to send `tx_data`.
- `tx_ready` out 1: high only in IDLE.
- `ps2_clk_i` in 1: PS/2 clock pad input (asynchronous).
- `ps2_data_i` in 1: PS/2 data pad input (asynchronous).
- `ps2_clk_oe` out 1: 1 pulls the clock line low; 0 releases it.
- `ps2_data_oe` out 1: 1 pulls the data line low; 0 releases it.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at the end of a transfer.
- `err_ack` out 1: valid with `done`; 1 means no acknowledge from the device.
- `err_timeout` out 1: valid with `done`; 1 means the device clock timed out.

## Operation
- Inputs pass through a 2-flop synchronizer. A falling edge (`fe`) is synced-previous=1 and synced-current=0.
- States:
  - IDLE: on `tx_valid`&`tx_ready`, latch the byte and compute parity = ~^data (odd). Go to INHIBIT.
  - INHIBIT: `clk_oe`=1 for INHIBIT_CYC cycles, then REQ.
  - REQ: `clk_oe`=1, `data_oe`=1 for REQ_CYC cycles. Then release the clock and go to SHIFT with edge count k=0.
  - SHIFT: `data_oe` stays 1 (start bit) until the first `fe`. On each `fe`, k increments:
    - k=1..8: present data bit k-1, LSB first, `data_oe`=~bit.
    - k=9: present parity.
    - k=10: release data (stop bit), go to ACK.
  - ACK: on the next `fe`, sample synced data. Set `err_ack`=1 if it is high. Go to WAIT_IDLE.
  - WAIT_IDLE: both lines released. When synced clock and data are both high, pulse `done` and return to IDLE.
- Timeout: a counter reloads on entry to SHIFT and on every `fe` in SHIFT/ACK. If it reaches TIMEOUT_CYC:
  - release both lines;
  - set `err_timeout`=1 and `err_ack`=0;
  - pulse `done` immediately and return to IDLE (no WAIT_IDLE).
- `err_*` flags are registered and held until the next accept. They are cleared on accept.
- `tx_valid` while busy is ignored; no queuing.

## Timing
- Reset values: `tx_ready`=1, `ps2_clk_oe`=0, `ps2_data_oe`=0, `busy`=0, `done`=0, `err_ack`=0, `err_timeout`=0.
- Reset mid-transfer releases both lines on the cycle after `reset` is sampled high.
- Accept cycle N: `ps2_clk_oe`=1 and `busy`=1 at N+1.
- `ps2_data_oe`=1 at N+1+INHIBIT_CYC.
- `ps2_clk_oe`=0 at N+1+INHIBIT_CYC+REQ_CYC.
- Data update lags a pad falling edge by 3 cycles (2 sync + 1 register). This is well inside the device's low half-period of at least 30 us.
- `done` is high for exactly one cycle, and `tx_ready` returns high the cycle after `done`.
- A device clock glitch shorter than 2 cycles may be missed. That is acceptable; the timeout catches a stalled transfer.

## Structure
- Package `ps2_pkg`:
  - state enum `ps2_tx_st_t` (IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE);
  - default cycle constants;
  - scancode/command constants shared with the receiver and benches (0xED, 0xFF, 0xF0, 0xFA).
- Sub-module `ps2_sync_edge`: 2-flop synchronizer plus falling-edge detector. One instance each for clock and data (the data instance uses only the synced level). The same sub-module is reusable by the receiver.
- `ps2_host_tx` holds the FSM, the shift register, the bit counter and the timeout counter.
- The top level builds the tristate pads as `pad = oe ? 1'b0 : 1'bz`.

## Test plan
- The bench device model runs at a 1500-cycle clock period and acks on edge 11:
  - Send 0xED: bits 1,0,1,1,0,1,1,1 LSB first, then parity 1 → `done` with `err_ack`=0, `err_timeout`=0.
  - Send 0x07: parity 0 → `done`, no errors.
  - Send 0x00: parity 1 → `done`, no errors.
- Device model omits the ack (data stays high on edge 11) → `done` with `err_ack`=1.
- Device never clocks after release → `done` exactly TIMEOUT_CYC cycles after entering SHIFT, with `err_timeout`=1 and both OEs 0.
- Assert `reset` during SHIFT at k=4 → both OEs 0 and `tx_ready`=1 on the next cycle. A following 0xFF send then completes cleanly.
- Pulse `tx_valid` with 0x55 while busy → ignored. Only the original byte appears on the line, followed by a single `done`.
